// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants and types for the AES-256 key schedule.
//   AES_ROUNDS  : number of cipher rounds (14 for AES-256)
//   AES256_NK   : key length in 32-bit words (8)
//   AES_NWORDS  : expanded schedule length in words (60)
//   AES_RCON    : round constants, index 0 unused, 1..7 used by AES-256
//   keyexp_state_e : key-expansion controller states
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_ROUNDS = 14;
   localparam int AES256_NK  = 8;
   localparam int AES_NWORDS = 4 * (AES_ROUNDS + 1);

   // Packed descending array: element 0 is the rightmost byte.
   localparam logic [7:0][7:0] AES_RCON = {
      8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GEN  = 2'd1,
      ST_FIN  = 2'd2
   } keyexp_state_e;

endpackage

// File: rtl/aes_sbox_lut.sv
// ---------------------------------------------------------------------------
// aes_sbox_lut
// Combinational AES forward S-box, full 256-entry lookup table.
//   sbox_in  [7:0] : byte to substitute
//   sbox_out [7:0] : S(sbox_in)
// ---------------------------------------------------------------------------
module aes_sbox_lut (
   input  logic [7:0] sbox_in,
   output logic [7:0] sbox_out
);

   // Ascending packed range so the first listed byte is entry 0.
   localparam logic [0:255][7:0] SBOX_TABLE = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign sbox_out = SBOX_TABLE[sbox_in];

endmodule

// File: rtl/aes256_key_expand.sv
// ---------------------------------------------------------------------------
// aes256_key_expand
// Iterative AES-256 key schedule: one 32-bit schedule word per cycle, 15
// round keys (60 words) held in registers and read combinationally by index.
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   start            : begin expansion of key_in (only honoured in IDLE)
//   key_in   [255:0] : cipher key, key_in[255:224] is w0
//   zeroize          : synchronous wipe, only with AES_KEYEXP_ZEROIZE_EN
//   busy             : expansion in progress
//   done             : one-cycle pulse when all round keys are valid
//   rk_avail [3:0]   : number of complete round keys stored (0..15)
//   rk_idx   [3:0]   : round-key read index
//   rk_data  [127:0] : round key rk_idx, zero for indices above 14
// Build option: define AES_KEYEXP_ZEROIZE_EN to add the zeroize port.
// ---------------------------------------------------------------------------
module aes256_key_expand
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [255:0] key_in,
`ifdef AES_KEYEXP_ZEROIZE_EN
   input  logic         zeroize,
`endif
   output logic         busy,
   output logic         done,
   output logic [3:0]   rk_avail,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk_data
);

   keyexp_state_e state_reg;
   logic [5:0]    i_reg;
   logic          busy_reg;
   logic          done_reg;
   logic [3:0]    rk_avail_reg;
   logic [31:0]   win_reg   [0:AES256_NK-1];
   logic [31:0]   store_reg [0:AES_NWORDS-1];

   logic          zeroize_req;
   logic [31:0]   key_word  [0:AES256_NK-1];
   logic [31:0]   w_prev;
   logic [31:0]   sub_in;
   logic [31:0]   sub_out;
   logic [31:0]   f_word;
   logic [31:0]   w_new;
   logic [127:0]  rk_table  [0:15];

`ifdef AES_KEYEXP_ZEROIZE_EN
   assign zeroize_req = zeroize;
`else
   assign zeroize_req = 1'b0;
`endif

   genvar gi;

   generate
      for (gi = 0; gi < AES256_NK; gi++) begin : g_key_word
         assign key_word[gi] = key_in[255-32*gi -: 32];
      end
   endgenerate

   // Window slot 7 holds w[i-1], slot 0 holds w[i-8].
   assign w_prev = win_reg[AES256_NK-1];
   assign sub_in = (i_reg[2:0] == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

   generate
      for (gi = 0; gi < 4; gi++) begin : g_subword
         aes_sbox_lut u_sbox (
            .sbox_in  (sub_in[8*gi +: 8]),
            .sbox_out (sub_out[8*gi +: 8])
         );
      end
   endgenerate

   always_comb begin
      f_word = w_prev;
      if (i_reg[2:0] == 3'd0) begin
         f_word = sub_out ^ {AES_RCON[i_reg[5:3]], 24'h0};
      end else if (i_reg[2:0] == 3'd4) begin
         f_word = sub_out;
      end
      w_new = win_reg[0] ^ f_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         i_reg        <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         rk_avail_reg <= '0;
         for (int k = 0; k < AES256_NK; k++) win_reg[k] <= '0;
         for (int k = 0; k < AES_NWORDS; k++) store_reg[k] <= '0;
      end else if (zeroize_req) begin
         // Wipe takes precedence over any start in the same cycle.
         state_reg    <= ST_IDLE;
         i_reg        <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         rk_avail_reg <= '0;
         for (int k = 0; k < AES256_NK; k++) win_reg[k] <= '0;
         for (int k = 0; k < AES_NWORDS; k++) store_reg[k] <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  for (int k = 0; k < AES256_NK; k++) begin
                     win_reg[k]   <= key_word[k];
                     store_reg[k] <= key_word[k];
                  end
                  i_reg        <= 6'd8;
                  busy_reg     <= 1'b1;
                  rk_avail_reg <= 4'd2;
                  state_reg    <= ST_GEN;
               end
            end
            ST_GEN: begin
               store_reg[i_reg] <= w_new;
               for (int k = 0; k < AES256_NK-1; k++) win_reg[k] <= win_reg[k+1];
               win_reg[AES256_NK-1] <= w_new;
               // Word 4k+3 completes round key k.
               if (i_reg[1:0] == 2'b11) rk_avail_reg <= rk_avail_reg + 4'd1;
               if (i_reg == 6'(AES_NWORDS-1)) begin
                  state_reg <= ST_FIN;
               end else begin
                  i_reg <= i_reg + 6'd1;
               end
            end
            ST_FIN: begin
               busy_reg     <= 1'b0;
               done_reg     <= 1'b1;
               rk_avail_reg <= 4'(AES_ROUNDS + 1);
               state_reg    <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Entry 15 is tied to zero so out-of-range indices read as 0.
   generate
      for (gi = 0; gi < 16; gi++) begin : g_rk_table
         if (gi <= AES_ROUNDS) begin : g_valid
            assign rk_table[gi] = {store_reg[4*gi], store_reg[4*gi+1],
                                   store_reg[4*gi+2], store_reg[4*gi+3]};
         end else begin : g_zero
            assign rk_table[gi] = '0;
         end
      end
   endgenerate

   assign rk_data  = rk_table[rk_idx];
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign rk_avail = rk_avail_reg;

endmodule

// File: tb/tb_aes256_key_expand.sv
// ---------------------------------------------------------------------------
// tb_aes256_key_expand
// Directed self-checking bench for aes256_key_expand using the FIPS-197 A.3
// key, the all-zero key, start-while-busy, mid-run reset and (when
// AES_KEYEXP_ZEROIZE_EN is defined) zeroize.
// ---------------------------------------------------------------------------
module tb_aes256_key_expand;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [255:0] key_in;
`ifdef AES_KEYEXP_ZEROIZE_EN
   logic         zeroize;
`endif
   logic         busy;
   logic         done;
   logic [3:0]   rk_avail;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;

   int checks = 0;
   int errors = 0;

   localparam logic [255:0] KEY_A3   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] KEY_ZERO = 256'h0;
   localparam logic [127:0] A3_RK0   = 128'h603deb1015ca71be2b73aef0857d7781;
   localparam logic [127:0] A3_RK1   = 128'h1f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] A3_RK2   = 128'h9ba354118e6925afa51a8b5f2067fcde;
   localparam logic [127:0] A3_RK3   = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
   localparam logic [127:0] A3_RK14  = 128'hfe4890d1e6188d0b046df344706c631e;
   localparam logic [127:0] Z_RK2    = 128'h62636363626363636263636362636363;
   localparam logic [127:0] Z_RK3    = 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb;

   aes256_key_expand dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .key_in   (key_in),
`ifdef AES_KEYEXP_ZEROIZE_EN
      .zeroize  (zeroize),
`endif
      .busy     (busy),
      .done     (done),
      .rk_avail (rk_avail),
      .rk_idx   (rk_idx),
      .rk_data  (rk_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic read_rk(input logic [3:0] idx, input string tag, input logic [127:0] exp);
      rk_idx = idx;
      #1;
      check(tag, rk_data, exp);
   endtask

   // Accept a key: start is high across one rising edge (edge T).
   task automatic accept(input logic [255:0] key);
      key_in = key;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   // Wait for done after edge T; returns the edge count at which it appeared, 0 if never.
   task automatic wait_done(input int already, output int done_at);
      done_at = 0;
      for (int k = already + 1; k <= 80; k++) begin
         tick();
         if (done === 1'b1) begin
            done_at = k;
            break;
         end
      end
   endtask

   initial begin
      int done_at;
      rst_n  = 1'b0;
      start  = 1'b0;
      key_in = '0;
      rk_idx = '0;
`ifdef AES_KEYEXP_ZEROIZE_EN
      zeroize = 1'b0;
`endif
      repeat (3) tick();

      // Reset state
      check("reset_busy", {127'b0, busy}, 128'd0);
      check("reset_done", {127'b0, done}, 128'd0);
      check("reset_rk_avail", {124'b0, rk_avail}, 128'd0);
      read_rk(4'd0, "reset_rk0", 128'd0);
      read_rk(4'd14, "reset_rk14", 128'd0);
      rst_n = 1'b1;
      tick();

      // A.3 vector with rk_avail progression
      $display("txn: expand A.3 key, track rk_avail");
      accept(KEY_A3);
      check("a3_busy_after_T", {127'b0, busy}, 128'd1);
      check("a3_avail_after_T", {124'b0, rk_avail}, 128'd2);
      read_rk(4'd0, "a3_rk0_early", A3_RK0);
      read_rk(4'd1, "a3_rk1_early", A3_RK1);
      done_at = 0;
      for (int k = 1; k <= 52; k++) begin
         tick();
         check($sformatf("a3_avail_T+%0d", k), {124'b0, rk_avail}, 128'(2 + k / 4));
         if (k == 4)  read_rk(4'd2, "a3_rk2_early", A3_RK2);
         if (k == 8)  read_rk(4'd3, "a3_rk3_early", A3_RK3);
         if (k == 52) read_rk(4'd14, "a3_rk14_early", A3_RK14);
         if (done === 1'b1 && done_at == 0) done_at = k;
      end
      check("a3_no_early_done", 128'(done_at), 128'd0);
      wait_done(52, done_at);
      check("a3_done_latency", 128'(done_at), 128'd53);
      check("a3_busy_at_done", {127'b0, busy}, 128'd0);
      check("a3_avail_at_done", {124'b0, rk_avail}, 128'd15);
      tick();
      check("a3_done_one_cycle", {127'b0, done}, 128'd0);
      read_rk(4'd1, "a3_rk1", A3_RK1);
      read_rk(4'd2, "a3_rk2", A3_RK2);
      check("a3_w8", {96'b0, rk_data[127:96]}, 128'h9ba35411);
      read_rk(4'd14, "a3_rk14", A3_RK14);

      // start while busy is ignored
      $display("txn: start with zero key at T+20 while busy");
      accept(KEY_A3);
      check("busy_restart_avail", {124'b0, rk_avail}, 128'd2);
      repeat (20) tick();
      accept(KEY_ZERO);
      wait_done(21, done_at);
      check("busy_start_done_latency", 128'(done_at), 128'd53);
      read_rk(4'd0, "busy_start_rk0", A3_RK0);
      read_rk(4'd2, "busy_start_rk2", A3_RK2);
      read_rk(4'd14, "busy_start_rk14", A3_RK14);
      tick();

      // Reset mid-GEN
      $display("txn: reset at T+30");
      accept(KEY_A3);
      repeat (30) tick();
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {127'b0, busy}, 128'd0);
      check("midrst_done", {127'b0, done}, 128'd0);
      check("midrst_avail", {124'b0, rk_avail}, 128'd0);
      for (int n = 0; n < 16; n++) read_rk(4'(n), $sformatf("midrst_rk%0d", n), 128'd0);
      tick();
      rst_n = 1'b1;
      tick();
      accept(KEY_A3);
      wait_done(0, done_at);
      check("postrst_done_latency", 128'(done_at), 128'd53);
      read_rk(4'd1, "postrst_rk1", A3_RK1);
      read_rk(4'd3, "postrst_rk3", A3_RK3);
      read_rk(4'd14, "postrst_rk14", A3_RK14);
      tick();

      // Out-of-range read and key reuse
      $display("txn: out-of-range read, zero key, then A.3 again");
      read_rk(4'd15, "oor_rk15", 128'd0);
      accept(KEY_ZERO);
      key_in = KEY_A3;    // must not affect the run in progress
      wait_done(0, done_at);
      check("zero_done_latency", 128'(done_at), 128'd53);
      read_rk(4'd0, "zero_rk0", 128'd0);
      read_rk(4'd2, "zero_rk2", Z_RK2);
      read_rk(4'd3, "zero_rk3", Z_RK3);
      tick();
      accept(KEY_A3);
      wait_done(0, done_at);
      read_rk(4'd0, "reuse_rk0", A3_RK0);
      read_rk(4'd2, "reuse_rk2", A3_RK2);
      read_rk(4'd14, "reuse_rk14", A3_RK14);
      tick();

`ifdef AES_KEYEXP_ZEROIZE_EN
      // zeroize together with start at T+10
      $display("txn: zeroize with start at T+10");
      accept(KEY_A3);
      repeat (9) tick();
      zeroize = 1'b1;
      key_in  = KEY_ZERO;
      start   = 1'b1;
      tick();
      zeroize = 1'b0;
      start   = 1'b0;
      check("zero_busy", {127'b0, busy}, 128'd0);
      check("zero_avail", {124'b0, rk_avail}, 128'd0);
      done_at = 0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) done_at = k;
      end
      check("zero_no_done_or_busy", 128'(done_at), 128'd0);
      check("zero_avail_later", {124'b0, rk_avail}, 128'd0);
      for (int n = 0; n < 16; n++) read_rk(4'(n), $sformatf("zero_rd%0d", n), 128'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
